// File: rtl/rv_mc_ctrl_ws.sv
// Multicycle RV32I control unit with data-memory wait states, SYSTEM halt,
// sticky error state and a retired-instruction counter.
module rv_mc_ctrl_ws #(
    parameter int MEM_WAIT_EN = 1,
    parameter int MAX_WAIT    = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [1:0]       pc_sel,
    output logic             en_pc,
    output logic             alu_src,
    output logic [2:0]       imm_src,
    output logic [3:0]       alu_action,
    output logic [1:0]       mem_to_reg,
    output logic             read_mem,
    output logic             write_mem,
    output logic             en_w,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] instret
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3,
                           A_SLTU = 4'd4, A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7,
                           A_OR = 4'd8, A_AND = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
    } state_t;

    state_t           state, state_d;
    logic [7:0]       wait_cnt;
    logic [CNT_W-1:0] instret_q;
    logic             alt, taken, mem_done, mem_timeout, is_store;
    logic [3:0]       arith;
    logic [2:0]       imm_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            wait_cnt  <= 8'd0;
            instret_q <= '0;
        end else begin
            state <= state_d;
            // Counter is zero on every MEM entry because it is held clear elsewhere.
            if (state != S_MEM)
                wait_cnt <= 8'd0;
            else if (!mem_ready && wait_cnt != 8'(MAX_WAIT))
                wait_cnt <= wait_cnt + 8'd1;
            if (en_pc)
                instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign instret = instret_q;

    // funct7b5 selects SUB only for R-type; SRA/SRAI for both.
    always_comb begin
        alt = funct7b5 && ((opcode == OP_R && funct3 == 3'b000) || funct3 == 3'b101);
        case (funct3)
            3'b000:  arith = alt ? A_SUB : A_ADD;
            3'b001:  arith = A_SLL;
            3'b010:  arith = A_SLT;
            3'b011:  arith = A_SLTU;
            3'b100:  arith = A_XOR;
            3'b101:  arith = alt ? A_SRA : A_SRL;
            3'b110:  arith = A_OR;
            default: arith = A_AND;
        endcase
        case (opcode)
            OP_STORE:         imm_sel = 3'b001;
            OP_BR:            imm_sel = 3'b010;
            OP_LUI, OP_AUIPC: imm_sel = 3'b011;
            OP_JAL:           imm_sel = 3'b100;
            default:          imm_sel = 3'b000;
        endcase
    end

    assign taken       = funct3[2] ? (~zero ^ funct3[0]) : (zero ^ funct3[0]);
    assign mem_done    = (MEM_WAIT_EN == 0) || mem_ready;
    assign mem_timeout = (MEM_WAIT_EN != 0) && !mem_ready && (wait_cnt == 8'(MAX_WAIT));
    assign is_store    = (opcode == OP_STORE);

    always_comb begin
        state_d    = state;
        pc_sel     = 2'b00;
        en_pc      = 1'b0;
        alu_src    = 1'b0;
        imm_src    = 3'b000;
        alu_action = A_ADD;
        mem_to_reg = 2'b00;
        read_mem   = 1'b0;
        write_mem  = 1'b0;
        en_w       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
                    OP_LOAD, OP_STORE, OP_BR: state_d = S_EXEC;
                    OP_SYS:                   state_d = S_HALT;
                    default:                  state_d = S_ERR;
                endcase
            end
            S_EXEC: begin
                imm_src = imm_sel;
                alu_src = (opcode != OP_R) && (opcode != OP_BR);
                state_d = S_WB;
                case (opcode)
                    OP_R, OP_I:         alu_action = arith;
                    OP_LOAD, OP_STORE:  state_d = S_MEM;
                    OP_BR: begin
                        alu_action = funct3[2] ? (funct3[1] ? A_SLTU : A_SLT) : A_SUB;
                        en_pc      = 1'b1;
                        pc_sel     = taken ? 2'b01 : 2'b00;
                        state_d    = S_FETCH;
                    end
                    default:            alu_action = A_ADD;
                endcase
            end
            S_MEM: begin
                read_mem  = !is_store;
                write_mem = is_store;
                if (mem_timeout)
                    state_d = S_ERR;
                else if (mem_done) begin
                    en_pc   = is_store;
                    state_d = is_store ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                en_w    = 1'b1;
                en_pc   = 1'b1;
                imm_src = imm_sel;
                state_d = S_FETCH;
                case (opcode)
                    OP_JAL:  begin pc_sel = 2'b01; mem_to_reg = 2'b10; end
                    OP_JALR: begin pc_sel = 2'b10; mem_to_reg = 2'b10; end
                    OP_LOAD: mem_to_reg = 2'b01;
                    OP_LUI:  mem_to_reg = 2'b11;
                    default: mem_to_reg = 2'b00;
                endcase
            end
            S_HALT: begin
                done = 1'b1;
                if (start) state_d = S_FETCH;
            end
            default: err = 1'b1;
        endcase
    end
endmodule
